// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and handshake pulses.
// Occupancy flags decode a separate entry counter so FIFO_DEPTH need not be a power of two.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  wr_ok;
  logic                  rd_ok;

  // Explicit wrap keeps non-power-of-two depths in range.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign almostfull  = (count == CW'(FIFO_DEPTH - 1));
  assign empty       = (count == '0);
  assign almostempty = (count == CW'(1));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_ok;
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= next_ptr(rd_ptr);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
